// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU select codes and FSM state encoding.
package alu_share_arbiter_pkg;

    localparam logic [2:0] SEL_PASS_B = 3'b000;
    localparam logic [2:0] SEL_SLT    = 3'b001;
    localparam logic [2:0] SEL_ADD    = 3'b010;
    localparam logic [2:0] SEL_SUB    = 3'b011;
    localparam logic [2:0] SEL_PASS_A = 3'b100;
    localparam logic [2:0] SEL_MUL    = 3'b101;
    localparam logic [2:0] SEL_EQ     = 3'b110;
    localparam logic [2:0] SEL_AND    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic is_mul(input logic [2:0] sel);
        return sel == SEL_MUL;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin pick: combinational grant, pointer moves past the winner on advance.
module alu_share_arbiter_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output logic       gnt_idx
);

    logic ptr_q, ptr_d;

    always_comb begin
        gnt_idx = 1'b0;
        case (req)
            2'b11:   gnt_idx = ptr_q;
            2'b10:   gnt_idx = 1'b1;
            default: gnt_idx = 1'b0;
        endcase
        if (req == 2'b00) begin
            gnt = 2'b00;
        end else begin
            gnt = gnt_idx ? 2'b10 : 2'b01;
        end
        ptr_d = advance ? ~gnt_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; holds operands for the op latency
// and returns the registered result over a per-port response handshake.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [2:0]       req_sel0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [2:0]       req_sel1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_select,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             busy
);

    localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CntW-1:0] MulLoad = CntW'(MUL_CYCLES - 1);

    state_e           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic [1:0]       arb_gnt;
    logic             arb_idx;
    logic             handshake;
    logic [2:0]       win_sel;

    alu_share_arbiter_rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (handshake),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Gated by rst_n so the accept is low for the whole time reset is asserted.
    assign req_ready = (rst_n && state_q == IDLE) ? arb_gnt : 2'b00;
    assign handshake = |req_ready;
    assign win_sel   = arb_idx ? req_sel1 : req_sel0;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_zero_d  = rsp_zero_q;

        case (state_q)
            IDLE: begin
                if (handshake) begin
                    gnt_d     = arb_idx;
                    alu_a_d   = arb_idx ? req_a1 : req_a0;
                    alu_b_d   = arb_idx ? req_b1 : req_b0;
                    alu_sel_d = win_sel;
                    cnt_d     = is_mul(win_sel) ? MulLoad : '0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Equality is resolved here rather than trusting the ALU's flag encoding.
                    if (alu_sel_q == SEL_EQ) begin
                        rsp_y_d    = '0;
                        rsp_zero_d = (alu_a_q == alu_b_q);
                    end else begin
                        rsp_y_d    = alu_y;
                        rsp_zero_d = alu_zero;
                    end
                    rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= SEL_PASS_B;
            rsp_valid_q <= 2'b00;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_select = alu_sel_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_y      = rsp_y_q;
    assign rsp_zero   = rsp_zero_q;
    assign busy       = (state_q != IDLE);

endmodule
